// File: rtl/sa_feeder.sv
// Operand feeder for the systolic array.
// Buffers one K-deep tile of X (one column per beat) and W (one row per beat), then
// streams both into the array edges with a one-cycle-per-lane diagonal skew. Around the
// stream it emits the array's per-job synchronous clear and start pulse. After a drain
// period it pulses O_DONE for the controller.
//
// Load handshake: a beat transfers on a rising edge where I_LOAD_VLD and O_LOAD_RDY are
// both high. O_LOAD_RDY does not depend on I_LOAD_VLD. It is high only in IDLE and LOAD.
// While O_LOAD_RDY is low, I_LOAD_VLD is ignored and nothing is stored.
//
// FLUSH_CYC is expected to be >= 1 and K >= 1.

module sa_feeder #(
  parameter int D_W       = 8,
  parameter int SA_R      = 16,
  parameter int SA_C      = 16,
  parameter int K         = 16,
  parameter int START_LAT = 2,
  parameter int FLUSH_CYC = 32
) (
  input  logic                       I_CLK,
  input  logic                       I_ASYN_RST,
  input  logic                       I_LOAD_VLD,
  output logic                       O_LOAD_RDY,
  input  logic [SA_R-1:0][D_W-1:0]   I_LOAD_X,
  input  logic [SA_C-1:0][D_W-1:0]   I_LOAD_W,
  output logic                       O_SA_SYNC_RSTN,
  output logic                       O_START,
  output logic [SA_R-1:0][D_W-1:0]   O_X,
  output logic [SA_C-1:0][D_W-1:0]   O_W,
  output logic                       O_BUSY,
  output logic                       O_DONE,
  output logic [2:0]                 O_DBG_STATE
);

  // Feed length: the last lane of the wider edge finishes max(SA_R,SA_C)-1 beats late.
  localparam int MAX_RC = (SA_R > SA_C) ? SA_R : SA_C;
  localparam int T_FEED = K + MAX_RC - 1;

  // The phase counter serves both LEAD (0..START_LAT) and FLUSH (0..FLUSH_CYC-1).
  localparam int PH_MAX = (START_LAT > FLUSH_CYC - 1) ? START_LAT : FLUSH_CYC - 1;
  localparam int PH_W   = (PH_MAX > 0) ? $clog2(PH_MAX + 1) : 1;
  localparam int LC_W   = $clog2(K + 1);
  localparam int FT_W   = $clog2(T_FEED + 1);
  localparam int KI_W   = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLR   = 3'd2,
    ST_LEAD  = 3'd3,
    ST_FEED  = 3'd4,
    ST_FLUSH = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t            state;
  logic [LC_W-1:0]   load_cnt;
  logic [PH_W-1:0]   ph;
  logic [FT_W-1:0]   feed_t;
  logic              accept;
  logic [KI_W-1:0]   wr_idx;

  // Tile storage: entry k holds beat k exactly as it arrived.
  logic [SA_R-1:0][D_W-1:0] x_buf [K];
  logic [SA_C-1:0][D_W-1:0] w_buf [K];

  logic [SA_R-1:0][D_W-1:0] feed_x;
  logic [SA_C-1:0][D_W-1:0] feed_w;

  assign accept      = I_LOAD_VLD & O_LOAD_RDY;
  assign wr_idx      = load_cnt[KI_W-1:0];
  assign O_DBG_STATE = state;

  // Tile buffer write; contents need no reset because every slot is rewritten per job.
  always_ff @(posedge I_CLK) begin
    if (accept) begin
      x_buf[wr_idx] <= I_LOAD_X;
      w_buf[wr_idx] <= I_LOAD_W;
    end
  end

  // Skewed feed beat for index feed_t: lane n carries tile element feed_t-n, or zero outside the tile.
  always_comb begin : feed_mux
    int d;
    d      = 0;
    feed_x = '0;
    feed_w = '0;
    for (int i = 0; i < SA_R; i++) begin
      d = int'(feed_t) - i;
      if (d >= 0 && d < K) feed_x[i] = x_buf[KI_W'(d)][i];
    end
    for (int j = 0; j < SA_C; j++) begin
      d = int'(feed_t) - j;
      if (d >= 0 && d < K) feed_w[j] = w_buf[KI_W'(d)][j];
    end
  end

  // Job sequencer; every output is registered alongside the state it belongs to.
  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) begin
      state          <= ST_IDLE;
      load_cnt       <= '0;
      ph             <= '0;
      feed_t         <= '0;
      O_LOAD_RDY     <= 1'b1;
      O_SA_SYNC_RSTN <= 1'b1;
      O_START        <= 1'b0;
      O_X            <= '0;
      O_W            <= '0;
      O_BUSY         <= 1'b0;
      O_DONE         <= 1'b0;
    end else begin
      // Single-cycle pulses fall back to their idle level unless re-asserted below.
      O_START        <= 1'b0;
      O_DONE         <= 1'b0;
      O_SA_SYNC_RSTN <= 1'b1;
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            O_BUSY <= 1'b1;
            if (load_cnt == LC_W'(K - 1)) begin
              // Last beat of the tile: close the load window and clear the array.
              state          <= ST_CLR;
              load_cnt       <= '0;
              O_LOAD_RDY     <= 1'b0;
              O_SA_SYNC_RSTN <= 1'b0;
            end else begin
              state    <= ST_LOAD;
              load_cnt <= load_cnt + LC_W'(1);
            end
          end
        end
        ST_CLR: begin
          state   <= ST_LEAD;
          ph      <= '0;
          O_START <= 1'b1;
        end
        ST_LEAD: begin
          if (ph == PH_W'(START_LAT)) begin
            // feed_t is 0 here, so the first skewed beat is registered on this edge.
            state  <= ST_FEED;
            ph     <= '0;
            feed_t <= FT_W'(1);
            O_X    <= feed_x;
            O_W    <= feed_w;
          end else begin
            ph <= ph + PH_W'(1);
          end
        end
        ST_FEED: begin
          if (feed_t == FT_W'(T_FEED)) begin
            state  <= ST_FLUSH;
            feed_t <= '0;
            ph     <= '0;
            O_X    <= '0;
            O_W    <= '0;
          end else begin
            feed_t <= feed_t + FT_W'(1);
            O_X    <= feed_x;
            O_W    <= feed_w;
          end
        end
        ST_FLUSH: begin
          if (ph == PH_W'(FLUSH_CYC - 1)) begin
            state  <= ST_DONE;
            ph     <= '0;
            O_DONE <= 1'b1;
          end else begin
            ph <= ph + PH_W'(1);
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          O_LOAD_RDY <= 1'b1;
          O_BUSY     <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          load_cnt   <= '0;
          ph         <= '0;
          feed_t     <= '0;
          O_LOAD_RDY <= 1'b1;
          O_BUSY     <= 1'b0;
          O_X        <= '0;
          O_W        <= '0;
        end
      endcase
    end
  end

endmodule
